// File: rtl/lns_input_normalizer_pkg.sv
// Shared widths and field layout for the LNS input normaliser. The mantissa
// width is the one the downstream logarithm stage consumes on data_in.
package lns_input_normalizer_pkg;

    localparam int N_BITS   = 16;
    localparam int X_BITS   = 10;
    localparam int EXP_BITS = $clog2(N_BITS);

    // Pre-log fields carried beside the mantissa (stage-2 register and sideband FIFOs).
    typedef struct packed {
        logic                sign;
        logic                zero;
        logic [EXP_BITS-1:0] exp;
        logic [X_BITS-1:0]   mant;
    } lns_fields_t;

    // Magnitude of a two's-complement value as an unsigned N_BITS number.
    // The most negative input maps to 2^(N_BITS-1), which still fits unsigned.
    function automatic logic [N_BITS-1:0] abs_mag(input logic [N_BITS-1:0] value);
        logic [N_BITS-1:0] result;
        if (value[N_BITS-1]) begin
            result = ~value + {{(N_BITS-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/lns_input_normalizer_lod.sv
// Combinational priority encoder: index of the highest set bit plus an
// all-zero flag. Position reads 0 when the vector is all zeros.
module leading_one_detector #(
    parameter int N      = 16,
    parameter int P_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      vec,
    output logic [P_BITS-1:0] pos,
    output logic              all_zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        pos      = {P_BITS{1'b0}};
        all_zero = 1'b1;
        for (int i = 0; i < N; i++) begin
            pos      = vec[i] ? P_BITS'(i) : pos;
            all_zero = vec[i] ? 1'b0 : all_zero;
        end
    end

endmodule

// File: rtl/lns_input_normalizer.sv
// Two-stage elastic front end for the LNS logarithm: stage 1 captures sign and
// magnitude, stage 2 registers the leading-one position and the left-aligned
// fraction below it. Ready propagates combinationally back through both stages
// so a full pipe still moves one sample per cycle when downstream drains.
module lns_input_normalizer
    import lns_input_normalizer_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                data_in_valid,
    output logic                data_in_enable,
    input  logic [N_BITS-1:0]   data_in,
    output logic                data_out_valid,
    input  logic                data_out_enable,
    output logic [X_BITS-1:0]   mant_out,
    output logic [EXP_BITS-1:0] exp_out,
    output logic                sign_out,
    output logic                zero_out
);

    logic                s1_valid_r;
    logic                s1_sign_r;
    logic [N_BITS-1:0]   s1_mag_r;
    logic                s2_valid_r;
    lns_fields_t         s2_fields_r;

    logic                s1_ready_s;
    logic                s2_ready_s;
    logic                s1_load_s;
    logic                s2_load_s;
    logic [EXP_BITS-1:0] lod_pos_s;
    logic                lod_zero_s;
    logic [X_BITS-1:0]   mant_s;
    lns_fields_t         s2_next_s;

    assign s2_ready_s     = ~s2_valid_r | data_out_enable;
    assign s1_ready_s     = ~s1_valid_r | s2_ready_s;
    assign s1_load_s      = data_in_valid & s1_ready_s;
    assign s2_load_s      = s1_valid_r & s2_ready_s;
    assign data_in_enable = s1_ready_s;

    leading_one_detector #(
        .N      (N_BITS),
        .P_BITS (EXP_BITS)
    ) u_lod (
        .vec      (s1_mag_r),
        .pos      (lod_pos_s),
        .all_zero (lod_zero_s)
    );

    // Copy the bits below the leading one into the mantissa MSB-first; bits
    // that run past bit 0 pad with zeros, bits beyond X_BITS are truncated.
    always_comb begin
        mant_s = {X_BITS{1'b0}};
        for (int j = 0; j < X_BITS; j++) begin
            int k;
            k = int'(lod_pos_s) - 32'sd1 - j;
            if (k >= 32'sd0) begin
                mant_s[X_BITS-1-j] = s1_mag_r[k[EXP_BITS-1:0]];
            end else begin
                mant_s[X_BITS-1-j] = 1'b0;
            end
        end
    end

    // Assemble the stage-2 fields; a zero magnitude forces exp and mant to 0.
    always_comb begin
        s2_next_s.sign = s1_sign_r;
        s2_next_s.zero = lod_zero_s;
        if (lod_zero_s) begin
            s2_next_s.exp  = {EXP_BITS{1'b0}};
            s2_next_s.mant = {X_BITS{1'b0}};
        end else begin
            s2_next_s.exp  = lod_pos_s;
            s2_next_s.mant = mant_s;
        end
    end

    // Stage 1: capture sign and magnitude; empty out when the sample moves on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_mag_r   <= {N_BITS{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_sign_r  <= data_in[N_BITS-1];
            s1_mag_r   <= abs_mag(data_in);
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: register normalised fields; hold them until downstream accepts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_r  <= 1'b0;
            s2_fields_r <= '{sign: 1'b0, zero: 1'b0, exp: {EXP_BITS{1'b0}}, mant: {X_BITS{1'b0}}};
        end else if (s2_load_s) begin
            s2_valid_r  <= 1'b1;
            s2_fields_r <= s2_next_s;
        end else if (data_out_enable) begin
            s2_valid_r  <= 1'b0;
        end else begin
            s2_valid_r  <= s2_valid_r;
        end
    end

    assign data_out_valid = s2_valid_r;
    assign mant_out       = s2_fields_r.mant;
    assign exp_out        = s2_fields_r.exp;
    assign sign_out       = s2_fields_r.sign;
    assign zero_out       = s2_fields_r.zero;

endmodule
